// File: rtl/sobel_window_buffer.sv
// -----------------------------------------------------------------------------
// sobel_window_buffer
//
// Purpose:
//   Front end of the Sobel datapath. Takes a raster-order 8-bit grayscale
//   pixel stream, keeps the two previous image rows in two line-buffer RAMs,
//   and, for every pixel position that completes a full 3x3 neighbourhood,
//   presents that neighbourhood (row-major, P0 top-left .. P8 bottom-right)
//   together with a one-cycle start_calculations strobe. No border padding:
//   a frame yields (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows.
//
// Ports:
//   clk                 sole clock, rising edge
//   reset               asynchronous, active-high
//   pixel_in[7:0]       unsigned pixel, raster order
//   pixel_valid         pixel_in is accepted on this edge (no backpressure)
//   sof                 start-of-frame, qualifies pixel_in as (row 0, col 0)
//   windowBuffer[0:8]   registered 3x3 window, 8 bits per entry
//   start_calculations  one-cycle strobe: windowBuffer holds a new window
//   frame_done          one-cycle strobe with the last window of a frame
// -----------------------------------------------------------------------------
module sobel_window_buffer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pixel_in,
  input  logic       pixel_valid,
  input  logic       sof,
  output logic [7:0] windowBuffer [0:8],
  output logic       start_calculations,
  output logic       frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    FILL     = 2'd1,
    ACTIVE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [7:0]      win_q [0:8];
  logic [7:0]      win_d [0:8];
  logic            start_q, start_d;
  logic            done_q, done_d;

  // Line buffers: lb1 holds the previous row, lb2 the row before that.
  logic [7:0]      lb1_mem [0:IMG_WIDTH-1];
  logic [7:0]      lb2_mem [0:IMG_WIDTH-1];

  logic            accept_s;
  logic            last_pix_s;
  logic [CW-1:0]   addr_s;
  logic [7:0]      top_s;
  logic [7:0]      mid_s;

  // Pixels arriving before a start-of-frame are dropped; a sof pixel is
  // always taken, whatever the state, so a stream can resync at any time.
  assign accept_s   = pixel_valid && ((state_q != WAIT_SOF) || sof);

  // A sof pixel is forced to column 0, so the RAM address follows that.
  assign addr_s     = sof ? {CW{1'b0}} : col_q;

  assign last_pix_s = (row_q == ROW_LAST) && (col_q == COL_LAST);

  // Combinational read of the old contents; the write below lands on the
  // clock edge, which gives read-before-write within the cycle.
  assign top_s      = lb2_mem[addr_s];
  assign mid_s      = lb1_mem[addr_s];

  // Line-buffer write: shift the column down one row and store the new pixel.
  // Contents are deliberately not reset; rows 0-1 overwrite them before use.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb2_mem[addr_s] <= lb1_mem[addr_s];
      lb1_mem[addr_s] <= pixel_in;
    end
  end

  // State, counters, window and strobe registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_SOF;
      col_q   <= {CW{1'b0}};
      row_q   <= {RW{1'b0}};
      start_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      start_q <= start_d;
      done_q  <= done_d;
      win_q   <= win_d;
    end
  end

  // Next-state logic for the frame FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_SOF: begin
        if (pixel_valid && sof) begin
          state_d = FILL;
        end else begin
          state_d = WAIT_SOF;
        end
      end
      FILL: begin
        if (pixel_valid && sof) begin
          state_d = FILL;
        end else if (pixel_valid && (col_q == COL_LAST) && (row_q == RW'(1))) begin
          // Last pixel of row 1: the next pixel starts row 2.
          state_d = ACTIVE;
        end else begin
          state_d = FILL;
        end
      end
      ACTIVE: begin
        if (pixel_valid && sof) begin
          state_d = FILL;
        end else if (pixel_valid && last_pix_s) begin
          state_d = WAIT_SOF;
        end else begin
          state_d = ACTIVE;
        end
      end
      default: begin
        state_d = WAIT_SOF;
      end
    endcase
  end

  // Position counters, window shift and strobe generation.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    start_d = 1'b0;
    done_d  = 1'b0;

    if (accept_s) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = top_s;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = mid_s;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pixel_in;

      if (sof) begin
        // This pixel is (0,0); the next one is (0,1). No window here.
        col_d = CW'(1);
        row_d = {RW{1'b0}};
      end else begin
        // col >= 2 keeps windows from straddling the row boundary.
        if ((state_q == ACTIVE) && (row_q >= RW'(2)) && (col_q >= CW'(2))) begin
          start_d = 1'b1;
        end else begin
          start_d = 1'b0;
        end

        if (last_pix_s) begin
          done_d = (state_q == ACTIVE);
          col_d  = {CW{1'b0}};
          row_d  = {RW{1'b0}};
        end else if (col_q == COL_LAST) begin
          col_d = {CW{1'b0}};
          row_d = row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  assign windowBuffer       = win_q;
  assign start_calculations = start_q;
  assign frame_done         = done_q;

endmodule

// File: tb/tb_sobel_window_buffer.sv
// -----------------------------------------------------------------------------
// tb_sobel_window_buffer
//
// Self-checking bench for sobel_window_buffer with a 5x4 image and
// pixel = base + row*16 + col. A table of per-pixel vectors covers one
// continuous frame; hand-written sequences cover gaps, dropped pixels,
// resync, mid-frame reset and back-to-back frames.
// -----------------------------------------------------------------------------
module tb_sobel_window_buffer;

  localparam int W = 5;
  localparam int H = 4;

  logic       clk;
  logic       reset;
  logic [7:0] pixel_in;
  logic       pixel_valid;
  logic       sof;
  logic [7:0] windowBuffer [0:8];
  logic       start_calculations;
  logic       frame_done;

  int          n_checks;
  int          n_errors;
  int          strobe_cnt;
  int          done_cnt;
  logic [71:0] last_win;

  typedef struct {
    logic        s;
    logic [7:0]  pix;
    logic        exp_start;
    logic        exp_done;
    logic [71:0] exp_win;
  } vec_t;

  vec_t tbl [20];

  sobel_window_buffer #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .pixel_in          (pixel_in),
    .pixel_valid       (pixel_valid),
    .sof               (sof),
    .windowBuffer      (windowBuffer),
    .start_calculations(start_calculations),
    .frame_done        (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [71:0] pack_win();
    logic [71:0] v;
    v = 72'h0;
    for (int k = 0; k < 9; k++) begin
      v[71-8*k -: 8] = windowBuffer[k];
    end
    return v;
  endfunction

  // Window centred on (r-1, c-1), emitted when pixel (r, c) is accepted.
  function automatic logic [71:0] exp_window(int r, int c, logic [7:0] base);
    logic [71:0] v;
    v = 72'h0;
    for (int k = 0; k < 9; k++) begin
      v[71-8*k -: 8] = 8'((r - 2 + k / 3) * 16 + (c - 2 + k % 3)) + base;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Optional idle cycles (checked for hold), then one accepted pixel.
  task automatic accept_pix(input int r, input int c, input logic s, input int gap,
                            input logic [7:0] base);
    logic exp_s;
    logic exp_d;
    for (int g = 0; g < gap; g++) begin
      pixel_valid = 1'b0;
      sof         = 1'b0;
      pixel_in    = 8'hEE;
      tick();
      chk("gap_start", 72'(start_calculations), 72'h0);
      chk("gap_done", 72'(frame_done), 72'h0);
      chk("gap_hold", pack_win(), last_win);
    end
    pixel_valid = 1'b1;
    sof         = s;
    pixel_in    = 8'(r * 16 + c) + base;
    tick();
    exp_s = (r >= 2) && (c >= 2);
    exp_d = (r == H - 1) && (c == W - 1);
    chk("start", 72'(start_calculations), 72'(exp_s));
    chk("frame_done", 72'(frame_done), 72'(exp_d));
    if (exp_s) begin
      chk("window", pack_win(), exp_window(r, c, base));
    end
    if (start_calculations) strobe_cnt++;
    if (frame_done) done_cnt++;
    last_win    = pack_win();
    pixel_valid = 1'b0;
    sof         = 1'b0;
  endtask

  task automatic run_pix(input int n, input int gap, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      accept_pix(i / W, i % W, (i == 0), gap, base);
    end
  endtask

  task automatic idle_check(input string name);
    pixel_valid = 1'b0;
    sof         = 1'b0;
    tick();
    chk({name, "_start_low"}, 72'(start_calculations), 72'h0);
    chk({name, "_done_low"}, 72'(frame_done), 72'h0);
  endtask

  initial begin
    logic [71:0] first_w;
    logic [71:0] final_w;

    n_checks    = 0;
    n_errors    = 0;
    strobe_cnt  = 0;
    done_cnt    = 0;
    last_win    = 72'h0;
    first_w     = 72'h0;
    final_w     = 72'h0;
    reset       = 1'b1;
    pixel_valid = 1'b0;
    sof         = 1'b0;
    pixel_in    = 8'h00;

    for (int i = 0; i < 20; i++) begin
      tbl[i].s         = (i == 0);
      tbl[i].pix       = 8'((i / W) * 16 + (i % W));
      tbl[i].exp_start = ((i / W) >= 2) && ((i % W) >= 2);
      tbl[i].exp_done  = (i == 19);
      tbl[i].exp_win   = exp_window(i / W, i % W, 8'h00);
    end

    // Reset state, before any clock edge
    #2;
    chk("reset_window", pack_win(), 72'h0);
    chk("reset_start", 72'(start_calculations), 72'h0);
    chk("reset_done", 72'(frame_done), 72'h0);
    tick();
    tick();
    reset = 1'b0;

    // Full frame, continuous valid, table-driven
    for (int i = 0; i < 20; i++) begin
      pixel_valid = 1'b1;
      sof         = tbl[i].s;
      pixel_in    = tbl[i].pix;
      tick();
      chk("tbl_start", 72'(start_calculations), 72'(tbl[i].exp_start));
      chk("tbl_done", 72'(frame_done), 72'(tbl[i].exp_done));
      if (tbl[i].exp_start) begin
        chk("tbl_window", pack_win(), tbl[i].exp_win);
      end
      if (start_calculations) strobe_cnt++;
      if (frame_done) done_cnt++;
      if (i == 12) first_w = pack_win();
      if (i == 19) final_w = pack_win();
    end
    last_win = pack_win();
    chk("first_window", first_w, 72'h00_01_02_10_11_12_20_21_22);
    chk("last_window", final_w, 72'h12_13_14_22_23_24_32_33_34);
    chk("frame1_strobes", 72'(strobe_cnt), 72'd6);
    chk("frame1_done_cnt", 72'(done_cnt), 72'd1);
    idle_check("after_frame1");

    // Same frame with a gap before every pixel
    strobe_cnt = 0;
    done_cnt   = 0;
    run_pix(20, 1, 8'h00);
    chk("gapped_strobes", 72'(strobe_cnt), 72'd6);
    chk("gapped_done_cnt", 72'(done_cnt), 72'd1);

    // Reset, then 7 pixels without sof are dropped
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      pixel_valid = 1'b1;
      sof         = 1'b0;
      pixel_in    = 8'(8'h50 + i);
      tick();
      chk("nosof_start", 72'(start_calculations), 72'h0);
      chk("nosof_window", pack_win(), 72'h0);
    end
    last_win   = 72'h0;
    strobe_cnt = 0;
    done_cnt   = 0;
    run_pix(20, 0, 8'h00);
    chk("after_drop_strobes", 72'(strobe_cnt), 72'd6);
    chk("after_drop_done_cnt", 72'(done_cnt), 72'd1);

    // Resync: sof arrives at (2,3) of a running frame
    strobe_cnt = 0;
    done_cnt   = 0;
    run_pix(13, 0, 8'h00);
    chk("partial_no_done", 72'(done_cnt), 72'd0);
    run_pix(20, 0, 8'h40);
    chk("resync_strobes", 72'(strobe_cnt), 72'd7);
    chk("resync_done_cnt", 72'(done_cnt), 72'd1);

    // Asynchronous reset in the middle of row 2
    run_pix(14, 0, 8'h00);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_window", pack_win(), 72'h0);
    chk("async_rst_start", 72'(start_calculations), 72'h0);
    chk("async_rst_done", 72'(frame_done), 72'h0);
    tick();
    chk("rst_held_start", 72'(start_calculations), 72'h0);
    reset      = 1'b0;
    last_win   = 72'h0;
    strobe_cnt = 0;
    done_cnt   = 0;
    run_pix(20, 0, 8'h20);
    chk("post_rst_strobes", 72'(strobe_cnt), 72'd6);
    chk("post_rst_done_cnt", 72'(done_cnt), 72'd1);

    // Two back-to-back frames with distinct data
    strobe_cnt = 0;
    done_cnt   = 0;
    run_pix(20, 0, 8'h00);
    run_pix(20, 0, 8'h80);
    chk("b2b_strobes", 72'(strobe_cnt), 72'd12);
    chk("b2b_done_cnt", 72'(done_cnt), 72'd2);
    idle_check("after_b2b");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
